// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: regfile read, immediate generation, writeback bypass, RAW/WAW scoreboard.
// Latency: one cycle from acceptance (id_valid && id_ready) to ex_valid.
// Backpressure: id_ready drops on flush, on a pending hazard, or while execute holds a stalled instruction.
module operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_instr,
    output logic [4:0]      rf_r1,
    output logic [4:0]      rf_r2,
    input  logic [XLEN-1:0] rf_out_r1,
    input  logic [XLEN-1:0] rf_out_r2,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_instr,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            writes_rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            stall;
    logic            capture;
    logic            handoff;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign rd     = id_instr[11:7];
    assign rf_r1  = rs1;
    assign rf_r2  = rs2;

    assign writes_rd = (opcode != OP_STORE) && (opcode != OP_BRANCH);
    assign uses_rs1  = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2  = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    // Register r has a result still in flight: either an issued producer not yet written back
    // (a writeback landing this cycle resolves it), or the producer sitting in the execute register.
    function automatic logic pend(input logic [4:0] r);
        logic in_flight;
        logic in_ex;
        in_flight = busy[r] && !(wb_en && wb_rd == r);
        in_ex     = ex_valid && ex_rd_we && (ex_rd == r);
        return (r != 5'd0) && (in_flight || in_ex);
    endfunction

    // Immediate selection by instruction format, sign-extended; R-type and unknown give 0.
    always_comb begin
        imm = '0;
        case (opcode)
            OP_OPIMM, OP_LOAD, OP_JALR:
                imm = {{20{id_instr[31]}}, id_instr[31:20]};
            OP_STORE:
                imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
            OP_BRANCH:
                imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                       id_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {id_instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                       id_instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // The regfile write lands only at the next edge, so same-cycle writeback must be forwarded.
    assign op1 = (wb_en && wb_rd == rs1 && rs1 != 5'd0) ? wb_data : rf_out_r1;
    assign op2 = (wb_en && wb_rd == rs2 && rs2 != 5'd0) ? wb_data : rf_out_r2;

    assign stall    = (uses_rs1 && pend(rs1)) || (uses_rs2 && pend(rs2)) || (writes_rd && pend(rd));
    assign id_ready = !flush && !stall && (!ex_valid || ex_ready);
    assign capture  = id_valid && id_ready;
    // A flushed instruction is squashed even if execute was ready for it.
    assign handoff  = ex_valid && ex_ready && !flush;

    // Execute-side pipeline register: load on capture, drop on handoff or flush, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_instr   <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (capture) begin
                ex_valid <= 1'b1;
            end else if (handoff) begin
                ex_valid <= 1'b0;
            end
            if (capture) begin
                ex_pc      <= id_pc;
                ex_instr   <= id_instr;
                ex_rs1_val <= op1;
                ex_rs2_val <= op2;
                ex_imm     <= imm;
                ex_rd      <= rd;
                ex_rd_we   <= writes_rd && (rd != 5'd0);
            end
        end
    end

    // Scoreboard next state: set on handoff of a writer, clear on writeback; set wins; x0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (handoff && ex_rd_we) begin
            busy_nxt[ex_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  rf_r1;
    logic [4:0]  rf_r2;
    logic [31:0] rf_out_r1;
    logic [31:0] rf_out_r2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   waited;

    operand_fetch #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out_r1(rf_out_r1), .rf_out_r2(rf_out_r2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [4:0] rd, input logic we);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rs1 = r1; e.rs2 = r2; e.imm = imm; e.rd = rd; e.we = we;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Present an instruction (called at posedge+1) and hold it until accepted or the budget expires.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] r1v, input logic [31:0] r2v,
                         input logic push, input exp_t e, output int w);
        bit ok;
        id_pc = pc; id_instr = instr; rf_out_r1 = r1v; rf_out_r2 = r2v; id_valid = 1'b1;
        w = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id_ready) begin
                ok = 1'b1;
                break;
            end
            w++;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: instr %h never accepted, expected acceptance", instr);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    // Monitor: every real handoff to execute is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready && !flush) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL handoff_unexpected: got pc %h instr %h, expected no handoff", ex_pc, ex_instr);
            end else begin
                mon_e = sb.pop_front();
                if (ex_pc !== mon_e.pc || ex_instr !== mon_e.instr || ex_rs1_val !== mon_e.rs1 ||
                    ex_rs2_val !== mon_e.rs2 || ex_imm !== mon_e.imm || ex_rd_we !== mon_e.we ||
                    (mon_e.we && ex_rd !== mon_e.rd)) begin
                    n_fail++;
                    $display("FAIL handoff_payload: got pc=%h ins=%h r1=%h r2=%h imm=%h rd=%0d we=%b, expected pc=%h ins=%h r1=%h r2=%h imm=%h rd=%0d we=%b",
                             ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we,
                             mon_e.pc, mon_e.instr, mon_e.rs1, mon_e.rs2, mon_e.imm, mon_e.rd, mon_e.we);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_instr = 32'h002081B3;
        rf_out_r1 = '0; rf_out_r2 = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset state and combinational read addresses
        @(negedge clk);
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rf_r1_slice", {27'b0, rf_r1}, 32'd1);
        chk("rf_r2_slice", {27'b0, rf_r2}, 32'd2);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: addi x1,x0,5
        issue(32'h100, 32'h00500093, 32'h0, 32'h0, 1'b1,
              mk(32'h100, 32'h00500093, 32'h0, 32'h0, 32'd5, 5'd1, 1'b1), waited);

        // 2: add x2,x1,x1 stalls on x1 until its writeback, which is forwarded
        id_pc = 32'h104; id_instr = 32'h00108133; id_valid = 1'b1;
        rf_out_r1 = 32'hDEAD; rf_out_r2 = 32'hDEAD;
        @(negedge clk);
        chk("raw_ex_stall", {31'b0, id_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("raw_busy_stall", {31'b0, id_ready}, 32'd0);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        @(negedge clk);
        chk("bypass_accept", {31'b0, id_ready}, 32'd1);
        if (id_ready) sb.push_back(mk(32'h104, 32'h00108133, 32'd7, 32'd7, 32'd0, 5'd2, 1'b1));
        @(posedge clk); #1;
        wb_en = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;

        // 3: execute backpressure holds payload and blocks the next instruction
        id_pc = 32'h108; id_instr = 32'h00100213; rf_out_r1 = 32'h0; rf_out_r2 = 32'h11;
        id_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ex_valid", {31'b0, ex_valid}, 32'd1);
            chk("hold_ex_pc", ex_pc, 32'h104);
            chk("hold_ex_rs1", ex_rs1_val, 32'd7);
            chk("hold_id_ready", {31'b0, id_ready}, 32'd0);
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        issue(32'h108, 32'h00100213, 32'h0, 32'h11, 1'b1,
              mk(32'h108, 32'h00100213, 32'h0, 32'h11, 32'd1, 5'd4, 1'b1), waited);

        // addi x5,x2,0: x2 busy after the add handed off; cleared by writeback of 0x22
        id_pc = 32'h10C; id_instr = 32'h00010293; id_valid = 1'b1;
        @(negedge clk);
        chk("busy_x2_stall", {31'b0, id_ready}, 32'd0);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
        issue(32'h10C, 32'h00010293, 32'h55, 32'h0, 1'b1,
              mk(32'h10C, 32'h00010293, 32'h22, 32'h0, 32'd0, 5'd5, 1'b1), waited);
        wb_en = 1'b0;

        // 4: addi x3,x0,9 flushed while held in execute
        issue(32'h110, 32'h00900193, 32'h0, 32'h0, 1'b0,
              mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0), waited);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        @(posedge clk); #1;
        issue(32'h200, 32'h00118313, 32'h33, 32'h44, 1'b1,
              mk(32'h200, 32'h00118313, 32'h33, 32'h44, 32'd1, 5'd6, 1'b1), waited);
        chk("flush_no_busy_x3", waited, 32'd0);

        // 5: immediate formats
        issue(32'h204, 32'hFE112E23, 32'hA1, 32'hA2, 1'b1,
              mk(32'h204, 32'hFE112E23, 32'hA1, 32'hA2, 32'hFFFFFFFC, 5'd0, 1'b0), waited);
        issue(32'h208, 32'hFE000EE3, 32'h0, 32'h0, 1'b1,
              mk(32'h208, 32'hFE000EE3, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 1'b0), waited);
        issue(32'h20C, 32'h123450B7, 32'hB1, 32'hB2, 1'b1,
              mk(32'h20C, 32'h123450B7, 32'hB1, 32'hB2, 32'h12345000, 5'd1, 1'b1), waited);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h0;
        @(posedge clk); #1;
        wb_en = 1'b0;
        issue(32'h210, 32'h008000EF, 32'h0, 32'hC2, 1'b1,
              mk(32'h210, 32'h008000EF, 32'h0, 32'hC2, 32'd8, 5'd1, 1'b1), waited);
        chk("wb_clears_x1", waited, 32'd0);

        // 6: asynchronous reset with x5 busy and addi x8 held in execute
        issue(32'h214, 32'h00300413, 32'h0, 32'h0, 1'b0,
              mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0), waited);
        ex_ready = 1'b0;
        id_pc = 32'h218; id_instr = 32'h00028393; id_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_id_ready", {31'b0, id_ready}, 32'd0);
        chk("pre_rst_ex_valid", {31'b0, ex_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("async_rst_ex_pc", ex_pc, 32'd0);
        chk("async_rst_busy_x5", {31'b0, id_ready}, 32'd1);
        id_valid = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
